// File: rtl/sap_core.sv
// Parametrised accumulator CPU: mux datapath, variable-length microcode, C/Z flags, handshaked output.
// Instructions take 3-5 steps; step_en=0 stalls every register, and the out_valid pulse still drops after 1 clk.
module sap_core #(
    parameter int DW = 8,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          step_en,
    input  logic          prog_mode,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [DW-1:0] prog_data,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    output logic          halted,
    output logic [AW-1:0] pc_out,
    output logic          carry_flag,
    output logic          zero_flag
);

    localparam int DEPTH = 1 << AW;

    typedef enum logic [2:0] {T0, T1, T2, T3, T4} step_e;

    typedef enum logic [3:0] {
        OP_NOP = 4'd0,
        OP_LDA = 4'd1,
        OP_ADD = 4'd2,
        OP_SUB = 4'd3,
        OP_STA = 4'd4,
        OP_LDI = 4'd5,
        OP_JMP = 4'd6,
        OP_JC  = 4'd7,
        OP_JZ  = 4'd8,
        OP_OUT = 4'd14,
        OP_HLT = 4'd15
    } op_e;

    step_e         state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [AW-1:0] mar_q, mar_d;
    logic [DW-1:0] a_q, a_d;
    logic [DW-1:0] b_q, b_d;
    logic [DW-1:0] ir_q, ir_d;
    logic [DW-1:0] out_q, out_d;
    logic          c_q, c_d;
    logic          z_q, z_d;
    logic          ov_q, ov_d;
    logic          halt_q, halt_d;

    logic [DW-1:0] mem_q [DEPTH];
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rd;

    op_e           opc;
    logic [AW-1:0] opa;
    logic [DW-1:0] imm;
    logic          is_sub;
    logic [DW:0]   alu;

    assign mem_rd = mem_q[mar_q];
    assign opc    = op_e'(ir_q[DW-1:DW-4]);
    assign opa    = ir_q[AW-1:0];
    assign imm    = {4'b0000, ir_q[DW-5:0]};
    assign is_sub = (opc == OP_SUB);

    // SUB is A + ~B + 1, so the carry out reads as "no borrow".
    assign alu = {1'b0, a_q} + {1'b0, (is_sub ? ~b_q : b_q)} + {{DW{1'b0}}, is_sub};

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        mar_d     = mar_q;
        a_d       = a_q;
        b_d       = b_q;
        ir_d      = ir_q;
        out_d     = out_q;
        c_d       = c_q;
        z_d       = z_q;
        ov_d      = 1'b0;
        halt_d    = halt_q;
        mem_we    = 1'b0;
        mem_waddr = prog_addr;
        mem_wdata = prog_data;

        if (prog_mode) begin
            state_d = T0;
            pc_d    = '0;
            mar_d   = '0;
            a_d     = '0;
            b_d     = '0;
            ir_d    = '0;
            c_d     = 1'b0;
            z_d     = 1'b0;
            halt_d  = 1'b0;
            mem_we  = prog_we;
        end else if (step_en && !halt_q) begin
            case (state_q)
                T0: begin
                    mar_d   = pc_q;
                    state_d = T1;
                end
                T1: begin
                    ir_d    = mem_rd;
                    pc_d    = pc_q + {{(AW-1){1'b0}}, 1'b1};
                    state_d = T2;
                end
                T2: begin
                    state_d = T0;
                    case (opc)
                        OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                            mar_d   = opa;
                            state_d = T3;
                        end
                        OP_LDI: a_d = imm;
                        OP_JMP: pc_d = opa;
                        OP_JC:  if (c_q) pc_d = opa;
                        OP_JZ:  if (z_q) pc_d = opa;
                        OP_OUT: begin
                            out_d = a_q;
                            ov_d  = 1'b1;
                        end
                        OP_HLT: halt_d = 1'b1;
                        default: ;
                    endcase
                end
                T3: begin
                    state_d = T0;
                    case (opc)
                        OP_LDA: a_d = mem_rd;
                        OP_ADD, OP_SUB: begin
                            b_d     = mem_rd;
                            state_d = T4;
                        end
                        OP_STA: begin
                            mem_we    = 1'b1;
                            mem_waddr = mar_q;
                            mem_wdata = a_q;
                        end
                        default: ;
                    endcase
                end
                T4: begin
                    c_d     = alu[DW];
                    a_d     = alu[DW-1:0];
                    z_d     = (alu[DW-1:0] == '0);
                    state_d = T0;
                end
                default: state_d = T0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= T0;
            pc_q    <= '0;
            mar_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            ir_q    <= '0;
            out_q   <= '0;
            c_q     <= 1'b0;
            z_q     <= 1'b0;
            ov_q    <= 1'b0;
            halt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            mar_q   <= mar_d;
            a_q     <= a_d;
            b_q     <= b_d;
            ir_q    <= ir_d;
            out_q   <= out_d;
            c_q     <= c_d;
            z_q     <= z_d;
            ov_q    <= ov_d;
            halt_q  <= halt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign out_data   = out_q;
    assign out_valid  = ov_q;
    assign halted     = halt_q;
    assign pc_out     = pc_q;
    assign carry_flag = c_q;
    assign zero_flag  = z_q;

endmodule

// File: tb/tb_sap_core.sv
// Bench for sap_core: ISA-level reference model drives expectations at every instruction boundary and cycle.
module tb_sap_core;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       step_en = 1'b0;
    logic       prog_mode = 1'b0;
    logic       prog_we = 1'b0;
    logic [3:0] prog_addr = '0;
    logic [7:0] prog_data = '0;
    logic [7:0] out_data;
    logic       out_valid;
    logic       halted;
    logic [3:0] pc_out;
    logic       carry_flag;
    logic       zero_flag;

    logic        rst2 = 1'b0;
    logic        step_en2 = 1'b0;
    logic        prog_mode2 = 1'b0;
    logic        prog_we2 = 1'b0;
    logic [5:0]  prog_addr2 = '0;
    logic [11:0] prog_data2 = '0;
    logic [11:0] out_data2;
    logic        out_valid2;
    logic        halted2;
    logic [5:0]  pc_out2;
    logic        carry_flag2;
    logic        zero_flag2;

    always #5 clk = ~clk;

    sap_core dut (
        .clk(clk), .rst(rst), .step_en(step_en), .prog_mode(prog_mode),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .out_data(out_data), .out_valid(out_valid), .halted(halted),
        .pc_out(pc_out), .carry_flag(carry_flag), .zero_flag(zero_flag)
    );

    sap_core #(.DW(12), .AW(6)) dut2 (
        .clk(clk), .rst(rst2), .step_en(step_en2), .prog_mode(prog_mode2),
        .prog_we(prog_we2), .prog_addr(prog_addr2), .prog_data(prog_data2),
        .out_data(out_data2), .out_valid(out_valid2), .halted(halted2),
        .pc_out(pc_out2), .carry_flag(carry_flag2), .zero_flag(zero_flag2)
    );

    int checks = 0;
    int errors = 0;

    // Reference machine state, instruction-granular.
    int m_mem [16];
    int m_pc, m_a, m_c, m_z, m_out, m_halt;
    int img [16];
    bit tog;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int ins(input int opc, input int opd);
        return opc * 16 + opd;
    endfunction

    task automatic model_step(output int n, output bit isout);
        int w, opc, opd, r;
        w     = m_mem[m_pc];
        m_pc  = (m_pc + 1) % 16;
        opc   = w / 16;
        opd   = w % 16;
        n     = 3;
        isout = 1'b0;
        case (opc)
            1: begin m_a = m_mem[opd]; n = 4; end
            2: begin
                r = m_a + m_mem[opd];
                m_c = (r > 255) ? 1 : 0; m_a = r % 256; m_z = (m_a == 0) ? 1 : 0; n = 5;
            end
            3: begin
                r = m_a - m_mem[opd];
                m_c = (r >= 0) ? 1 : 0; m_a = (r + 256) % 256; m_z = (m_a == 0) ? 1 : 0; n = 5;
            end
            4: begin m_mem[opd] = m_a; n = 4; end
            5: m_a = opd;
            6: m_pc = opd;
            7: if (m_c != 0) m_pc = opd;
            8: if (m_z != 0) m_pc = opd;
            14: begin m_out = m_a; isout = 1'b1; end
            15: m_halt = 1;
            default: ;
        endcase
    endtask

    task automatic do_reset();
        rst = 1'b0;
        prog_mode = 1'b0;
        step_en = 1'b0;
        @(posedge clk); #1;
        chk("rst_pc", 32'(pc_out), 32'(0));
        chk("rst_out", 32'(out_data), 32'(0));
        chk("rst_ov", 32'(out_valid), 32'(0));
        chk("rst_halt", 32'(halted), 32'(0));
        chk("rst_c", 32'(carry_flag), 32'(0));
        chk("rst_z", 32'(zero_flag), 32'(0));
        for (int i = 0; i < 16; i++) m_mem[i] = 0;
        m_out = 0;
        rst = 1'b1;
    endtask

    task automatic load(input logic [15:0] wmask);
        prog_mode = 1'b1;
        prog_we   = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 16; i++) begin
            if (wmask[i]) begin
                prog_we   = 1'b1;
                prog_addr = 4'(i);
                prog_data = 8'(img[i]);
                m_mem[i]  = img[i];
                @(posedge clk); #1;
            end
        end
        prog_we = 1'b0;
        m_pc = 0; m_a = 0; m_c = 0; m_z = 0; m_halt = 0;
        chk("prog_pc", 32'(pc_out), 32'(0));
        chk("prog_halt", 32'(halted), 32'(0));
        chk("prog_cz", 32'({carry_flag, zero_flag}), 32'(0));
        chk("prog_out_kept", 32'(out_data), 32'(m_out));
        prog_mode = 1'b0;
    endtask

    // mode 0: step_en held high, 1: toggled every cycle, 2: random.
    task automatic run(input int max_instr, input int mode, output int cyc);
        int n, done;
        bit isout, se;
        cyc = 0;
        tog = 1'b1;
        for (int k = 0; k < max_instr && m_halt == 0; k++) begin
            model_step(n, isout);
            done = 0;
            while (done < n) begin
                case (mode)
                    0: se = 1'b1;
                    1: begin se = tog; tog = !tog; end
                    default: se = ($urandom_range(0, 2) != 0);
                endcase
                step_en = se;
                @(posedge clk); #1;
                cyc++;
                if (se) done++;
                if (done < n) chk("ov_idle", 32'(out_valid), 32'(0));
            end
            chk("pc", 32'(pc_out), 32'(m_pc));
            chk("c", 32'(carry_flag), 32'(m_c));
            chk("z", 32'(zero_flag), 32'(m_z));
            chk("halt", 32'(halted), 32'(m_halt));
            chk("out", 32'(out_data), 32'(m_out));
            chk("ov", 32'(out_valid), 32'(isout));
        end
        step_en = 1'b0;
    endtask

    task automatic set_img_add();
        for (int i = 0; i < 16; i++) img[i] = 0;
        img[0] = ins(1, 14); img[1] = ins(2, 15); img[2] = ins(14, 0); img[3] = ins(15, 0);
        img[14] = 5; img[15] = 3;
    endtask

    initial begin
        int c0, c1, cyc;
        bit seen, wrapped;
        int prev;

        do_reset();

        // Add and output
        set_img_add();
        load(16'hFFFF);
        run(20, 0, c0);
        chk("add_out", 32'(out_data), 32'(8));
        chk("add_cz", 32'({carry_flag, zero_flag}), 32'(0));
        chk("add_cycles", 32'(c0), 32'(15));
        // Halted core stays frozen
        step_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            chk("hlt_pc", 32'(pc_out), 32'(m_pc));
            chk("hlt_out", 32'(out_data), 32'(m_out));
            chk("hlt_ov", 32'(out_valid), 32'(0));
        end
        step_en = 1'b0;

        // Same program with step_en toggling: twice the cycles
        load(16'hFFFF);
        run(20, 1, c1);
        chk("stall_cycles", 32'(c1), 32'(2 * c0 - 1));
        chk("stall_out", 32'(out_data), 32'(8));

        // Carry through the JC path
        for (int i = 0; i < 16; i++) img[i] = 0;
        img[0] = ins(1, 14); img[1] = ins(2, 15); img[2] = ins(7, 6); img[3] = ins(14, 0);
        img[4] = ins(15, 0); img[5] = ins(15, 0); img[6] = ins(14, 0); img[7] = ins(15, 0);
        img[14] = 8'hF0; img[15] = 8'h20;
        load(16'hFFFF);
        run(20, 0, cyc);
        chk("carry_out", 32'(out_data), 32'(8'h10));
        chk("carry_c", 32'(carry_flag), 32'(1));
        chk("carry_pc", 32'(pc_out), 32'(8));

        // Zero / borrow with JZ
        for (int i = 0; i < 16; i++) img[i] = 0;
        img[0] = ins(1, 14); img[1] = ins(3, 15); img[2] = ins(8, 5); img[3] = ins(14, 0);
        img[4] = ins(15, 0); img[5] = ins(14, 0); img[6] = ins(15, 0);
        img[14] = 7; img[15] = 7;
        load(16'hFFFF);
        run(20, 2, cyc);
        chk("sub_eq_out", 32'(out_data), 32'(0));
        chk("sub_eq_cz", 32'({carry_flag, zero_flag}), 32'(2'b11));
        chk("sub_eq_pc", 32'(pc_out), 32'(7));
        img[15] = 8;
        load(16'hFFFF);
        run(20, 2, cyc);
        chk("sub_lt_out", 32'(out_data), 32'(8'hFF));
        chk("sub_lt_cz", 32'({carry_flag, zero_flag}), 32'(2'b00));
        chk("sub_lt_pc", 32'(pc_out), 32'(5));

        // All NOPs: PC wraps 15 -> 0
        for (int i = 0; i < 16; i++) img[i] = 0;
        load(16'hFFFF);
        run(15, 0, cyc);
        chk("nop_pc15", 32'(pc_out), 32'(15));
        run(1, 0, cyc);
        chk("nop_wrap", 32'(pc_out), 32'(0));

        // Random programs under random stalls
        for (int p = 0; p < 4; p++) begin
            for (int i = 0; i < 16; i++) img[i] = int'($urandom_range(0, 255));
            load(16'hFFFF);
            run(40, 2, cyc);
        end

        // Abort an STA in T2: target word must survive
        for (int i = 0; i < 16; i++) img[i] = 0;
        img[0] = ins(5, 9); img[1] = ins(4, 13); img[2] = ins(15, 0); img[13] = 8'h77;
        load(16'hFFFF);
        step_en = 1'b1;
        repeat (6) begin @(posedge clk); #1; end
        step_en = 1'b0;
        chk("abort_pc", 32'(pc_out), 32'(2));
        img[0] = ins(1, 13); img[1] = ins(14, 0); img[2] = ins(15, 0);
        load(16'h0007);
        run(10, 0, cyc);
        chk("abort_keep", 32'(out_data), 32'(8'h77));

        // Reset clears memory and out_data
        do_reset();
        load(16'h0007);
        run(10, 0, cyc);
        chk("rst_mem_clr", 32'(out_data), 32'(0));

        // Wide configuration DW=12, AW=6
        rst2 = 1'b0;
        @(posedge clk); #1;
        chk("w_rst_out", 32'(out_data2), 32'(0));
        rst2 = 1'b1;
        prog_mode2 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            prog_we2   = 1'b1;
            prog_addr2 = 6'(i);
            prog_data2 = (i == 0) ? 12'h5FF : (i == 1) ? 12'h43F : (i == 2) ? 12'h13F : 12'hE00;
            @(posedge clk); #1;
        end
        prog_we2 = 1'b0;
        prog_mode2 = 1'b0;
        step_en2 = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 200 && !seen; k++) begin
            @(posedge clk); #1;
            if (out_valid2) seen = 1'b1;
        end
        chk("w_ov_seen", 32'(seen), 32'(1));
        chk("w_out", 32'(out_data2), 32'(12'h0FF));
        wrapped = 1'b0;
        prev = int'(pc_out2);
        for (int k = 0; k < 1500 && !wrapped; k++) begin
            @(posedge clk); #1;
            if (prev == 63 && pc_out2 == 6'd0) wrapped = 1'b1;
            prev = int'(pc_out2);
        end
        chk("w_wrap", 32'(wrapped), 32'(1));
        chk("w_out_hold", 32'(out_data2), 32'(12'h0FF));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
